otter_cu_fsm: RTL and testbench

//  Multicycle control-unit state machine of the OTTER RV32I core. Sequences fetch, execute,

---
 rtl/otter_cu_fsm.sv | 167 ++++++++++++++++
 tb/tb_otter_cu_fsm.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/otter_cu_fsm.sv
// rtl/otter_cu_fsm.sv - OTTER RV32I multicycle control-unit state machine
module otter_cu_fsm #(
    parameter int INIT_CYCLES = 1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       INTR,
    input  logic       mie,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_we2,
    output logic       mem_rden1,
    output logic       mem_rden2,
    output logic       rst_out,
    output logic       csr_we,
    output logic       int_taken,
    output logic       mem_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_EXEC     = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_WB       = 3'd4,
        ST_INTRPT   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_CSR    = 7'b1110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    state_t     cur_state;
    state_t     nxt_state;
    logic [3:0] init_cnt;
    logic [7:0] wait_cnt;
    logic       is_load;
    logic       int_pend;
    logic       init_done;
    logic       timeout_hit;

    assign int_pend    = INTR & mie;
    assign init_done   = (init_cnt == 4'(INIT_CYCLES - 1));
    assign timeout_hit = (cur_state == ST_MEM_WAIT) && !mem_ready
                         && (wait_cnt == 8'(MEM_TIMEOUT - 1));
    assign state       = cur_state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cur_state <= ST_INIT;
            init_cnt  <= '0;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            is_load   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            init_cnt  <= (cur_state == ST_INIT && nxt_state == ST_INIT) ? init_cnt + 4'd1 : 4'd0;
            wait_cnt  <= (cur_state == ST_MEM_WAIT && nxt_state == ST_MEM_WAIT) ? wait_cnt + 8'd1 : 8'd0;
            if (timeout_hit)
                mem_err <= 1'b1;
            if (cur_state == ST_EXEC)
                is_load <= (opcode == OPC_LOAD);
        end
    end

    always_comb begin
        nxt_state = ST_INIT;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_we2   = 1'b0;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        rst_out   = 1'b0;
        csr_we    = 1'b0;
        int_taken = 1'b0;

        case (cur_state)
            ST_INIT: begin
                rst_out   = 1'b1;
                nxt_state = init_done ? ST_FETCH : ST_INIT;
            end
            ST_FETCH: begin
                mem_rden1 = 1'b1;
                nxt_state = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode)
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: begin
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    OPC_CSR: begin
                        pc_write = 1'b1;
                        if (func3 != 3'b000) begin
                            csr_we    = 1'b1;
                            reg_write = 1'b1;
                        end
                    end
                    OPC_LOAD: begin
                        mem_rden2 = 1'b1;
                    end
                    OPC_STORE: begin
                        mem_we2  = 1'b1;
                        pc_write = mem_ready;
                    end
                    default: pc_write = 1'b1;
                endcase
                if (pc_write)
                    nxt_state = int_pend ? ST_INTRPT : ST_FETCH;
                else if (opcode == OPC_LOAD && mem_ready)
                    nxt_state = ST_WB;
                else
                    nxt_state = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                mem_rden2 = is_load;
                mem_we2   = !is_load;
                if (mem_ready || timeout_hit) begin
                    if (is_load) begin
                        nxt_state = ST_WB;
                    end else begin
                        pc_write  = 1'b1;
                        nxt_state = int_pend ? ST_INTRPT : ST_FETCH;
                    end
                end else begin
                    nxt_state = ST_MEM_WAIT;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                nxt_state = int_pend ? ST_INTRPT : ST_FETCH;
            end
            ST_INTRPT: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
                nxt_state = ST_FETCH;
            end
            default: nxt_state = ST_INIT;
        endcase

        // Reset overrides everything combinationally so an in-flight access drops this cycle.
        if (RST) begin
            pc_write  = 1'b0;
            reg_write = 1'b0;
            mem_we2   = 1'b0;
            mem_rden1 = 1'b0;
            mem_rden2 = 1'b0;
            csr_we    = 1'b0;
            int_taken = 1'b0;
            rst_out   = 1'b1;
        end
    end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// tb/tb_otter_cu_fsm.sv - directed self-checking bench for otter_cu_fsm
module tb_otter_cu_fsm;

    logic       CLK = 1'b0;
    logic       RST, INTR, mie, mem_ready;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       pc_write, reg_write, mem_we2, mem_rden1, mem_rden2;
    logic       rst_out, csr_we, int_taken, mem_err;
    logic [2:0] state;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    localparam logic [7:0] PCW = 8'h80, RW = 8'h40, WE2 = 8'h20, RD1 = 8'h10;
    localparam logic [7:0] RD2 = 8'h08, RSO = 8'h04, CSW = 8'h02, INT = 8'h01;

    localparam logic [6:0] OP_IMM = 7'b0010011, LOAD = 7'b0000011, STORE = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011, CSR = 7'b1110011, ILLEGAL = 7'b0000000;

    otter_cu_fsm #(.INIT_CYCLES(1), .MEM_TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .INTR(INTR), .mie(mie), .opcode(opcode), .func3(func3),
        .mem_ready(mem_ready), .pc_write(pc_write), .reg_write(reg_write), .mem_we2(mem_we2),
        .mem_rden1(mem_rden1), .mem_rden2(mem_rden2), .rst_out(rst_out), .csr_we(csr_we),
        .int_taken(int_taken), .mem_err(mem_err), .state(state)
    );

    always #5 CLK = ~CLK;

    logic [7:0] outs;
    assign outs = {pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, rst_out, csr_we, int_taken};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [7:0] o);
        #1;
        chk({tag, ".state"}, {5'b0, state}, {5'b0, st});
        chk({tag, ".outs"}, outs, o);
    endtask

    initial begin
        RST = 1'b1; INTR = 1'b0; mie = 1'b0; mem_ready = 1'b0;
        opcode = OP_IMM; func3 = 3'b000;

        // reset and INIT
        tick(); expect_cyc("rst1", 3'd0, RSO);
        tick(); expect_cyc("rst2", 3'd0, RSO);
        chk("rst_mem_err", {7'b0, mem_err}, 8'h00);
        RST = 1'b0; expect_cyc("init", 3'd0, RSO);
        tick(); expect_cyc("fetch0", 3'd1, RD1);

        // ALU instructions, 2 cycles each
        tick(); expect_cyc("alu_exec1", 3'd2, PCW | RW);
        tick(); expect_cyc("alu_fetch1", 3'd1, RD1);
        tick(); expect_cyc("alu_exec2", 3'd2, PCW | RW);
        tick(); expect_cyc("alu_fetch2", 3'd1, RD1);
        chk("alu_mem_err", {7'b0, mem_err}, 8'h00);

        // load with three wait cycles
        opcode = LOAD;
        tick(); expect_cyc("ld_exec", 3'd2, RD2);
        tick(); expect_cyc("ld_mw1", 3'd3, RD2);
        tick(); expect_cyc("ld_mw2", 3'd3, RD2);
        tick(); mem_ready = 1'b1; expect_cyc("ld_mw3", 3'd3, RD2);
        tick(); mem_ready = 1'b0; expect_cyc("ld_wb", 3'd4, PCW | RW);
        tick(); expect_cyc("ld_fetch", 3'd1, RD1);
        chk("ld_mem_err", {7'b0, mem_err}, 8'h00);

        // store timing out after four wait cycles
        opcode = STORE;
        tick(); expect_cyc("st_exec", 3'd2, WE2);
        tick(); expect_cyc("st_mw1", 3'd3, WE2);
        tick(); expect_cyc("st_mw2", 3'd3, WE2);
        tick(); expect_cyc("st_mw3", 3'd3, WE2);
        tick(); expect_cyc("st_mw4", 3'd3, WE2 | PCW);
        chk("st_mw4_err", {7'b0, mem_err}, 8'h00);
        tick(); expect_cyc("st_fetch", 3'd1, RD1);
        chk("st_err_set", {7'b0, mem_err}, 8'h01);
        opcode = OP_IMM;
        tick(); expect_cyc("sticky_exec", 3'd2, PCW | RW);
        tick(); expect_cyc("sticky_fetch", 3'd1, RD1);
        chk("st_err_sticky", {7'b0, mem_err}, 8'h01);

        // reset abandons a store in MEM_WAIT
        opcode = STORE;
        tick(); expect_cyc("abort_exec", 3'd2, WE2);
        tick(); expect_cyc("abort_mw1", 3'd3, WE2);
        RST = 1'b1; expect_cyc("abort_rst", 3'd3, RSO);
        tick(); expect_cyc("abort_init", 3'd0, RSO);
        chk("abort_err_clr", {7'b0, mem_err}, 8'h00);
        RST = 1'b0; opcode = BRANCH;
        tick(); expect_cyc("abort_fetch", 3'd1, RD1);

        // branch with interrupt pending, then masked
        INTR = 1'b1; mie = 1'b1;
        tick(); expect_cyc("int_exec", 3'd2, PCW);
        tick(); expect_cyc("int_entry", 3'd5, PCW | INT);
        tick(); expect_cyc("int_fetch", 3'd1, RD1);
        mie = 1'b0;
        tick(); expect_cyc("mask_exec", 3'd2, PCW);
        tick(); expect_cyc("mask_fetch", 3'd1, RD1);
        INTR = 1'b0;

        // CSR write and mret
        opcode = CSR; func3 = 3'b001;
        tick(); expect_cyc("csrrw_exec", 3'd2, PCW | RW | CSW);
        tick(); expect_cyc("csrrw_fetch", 3'd1, RD1);
        func3 = 3'b000;
        tick(); expect_cyc("mret_exec", 3'd2, PCW);
        tick(); expect_cyc("mret_fetch", 3'd1, RD1);

        // unknown opcode, ready store, ready load
        opcode = ILLEGAL;
        tick(); expect_cyc("nop_exec", 3'd2, PCW);
        tick(); expect_cyc("nop_fetch", 3'd1, RD1);
        opcode = STORE; mem_ready = 1'b1;
        tick(); expect_cyc("st_rdy_exec", 3'd2, WE2 | PCW);
        tick(); expect_cyc("st_rdy_fetch", 3'd1, RD1);
        opcode = LOAD;
        tick(); expect_cyc("ld_rdy_exec", 3'd2, RD2);
        tick(); expect_cyc("ld_rdy_wb", 3'd4, PCW | RW);
        tick(); expect_cyc("ld_rdy_fetch", 3'd1, RD1);
        chk("final_mem_err", {7'b0, mem_err}, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
